player_checker: RTL and testbench

PLAYER_CHECKER -- requirements
Module: player_checker

---
 rtl/genius_pkg.sv | 36 +++
 rtl/press_detect.sv | 37 +++
 rtl/player_checker.sv | 117 +++++++++++
 tb/tb_player_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the player-input checker and the sequence store:
// index width, button value encoding and the checker state encoding.
package genius_pkg;

    localparam int IDX_W = 4;
    localparam int BTN_W = 3;

    // Button values; the sequence store uses the same encoding.
    localparam logic [1:0] ZERO = 2'd0;
    localparam logic [1:0] ONE  = 2'd1;
    localparam logic [1:0] TWO  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_WAIT_PRESS = 3'd2,
        ST_RELEASE    = 3'd3,
        ST_OK         = 3'd4,
        ST_FAIL       = 3'd5
    } state_e;

    function automatic logic btn_is_onehot(input logic [BTN_W-1:0] b);
        return (b == 3'b001) || (b == 3'b010) || (b == 3'b100);
    endfunction

    function automatic logic [1:0] btn_value(input logic [BTN_W-1:0] b);
        logic [1:0] v;
        case (b)
            3'b010:  v = ONE;
            3'b100:  v = TWO;
            default: v = ZERO;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/press_detect.sv
// Rising-edge press detector on the debounced button bus, with one-hot
// qualification and value decode of the pressed button.
module press_detect
    import genius_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [BTN_W-1:0] btn_i,
    output logic             press_o,
    output logic             onehot_o,
    output logic [1:0]       value_o,
    output logic             idle_o
);

    logic [BTN_W-1:0] btn_q;
    logic             armed_q;
    logic             armed_d;

    // A press only counts once an all-released sample has been taken since reset.
    assign armed_d = armed_q | (btn_i == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            btn_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            btn_q   <= btn_i;
            armed_q <= armed_d;
        end
    end

    assign idle_o   = (btn_i == '0);
    assign press_o  = armed_q && (btn_q == '0) && (btn_i != '0);
    assign onehot_o = btn_is_onehot(btn_i);
    assign value_o  = btn_value(btn_i);

endmodule

// File: rtl/player_checker.sv
// Checks one round of player button presses against the sequence store,
// with a per-press timeout, and reports round_ok / round_fail pulses.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | waiting for start; sequence_count holds last index
// FETCH       | one cycle for the store to present current_number
// WAIT_PRESS  | waiting for a new press, timeout running
// RELEASE     | correct press seen, waiting for all buttons released
// OK          | round_ok pulse
// FAIL        | round_fail pulse
module player_checker
    import genius_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] round_len,
    input  logic [BTN_W-1:0] btn,
    input  logic [1:0]       current_number,
    output logic [IDX_W-1:0] sequence_count,
    output logic             busy,
    output logic             round_ok,
    output logic             round_fail
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] seq_q, seq_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [TW-1:0]    timer_q, timer_d;

    logic             press;
    logic             onehot;
    logic [1:0]       value;
    logic             btn_idle;

    press_detect u_press_detect (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .btn_i    (btn),
        .press_o  (press),
        .onehot_o (onehot),
        .value_o  (value),
        .idle_o   (btn_idle)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            len_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        len_d   = len_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = round_len;
                    seq_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Down-counter armed on entry; terminal count 0 ends the last allowed cycle.
                timer_d = TW'(TIMEOUT_CYCLES - 1);
                state_d = ST_WAIT_PRESS;
            end
            ST_WAIT_PRESS: begin
                if (press) begin
                    if (!onehot || (value != current_number)) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else if (timer_q == '0) begin
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_RELEASE: begin
                if (btn_idle) begin
                    if (seq_q == len_q) begin
                        state_d = ST_OK;
                    end else begin
                        seq_d   = seq_q + IDX_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_OK:   state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign sequence_count = seq_q;
    assign busy           = (state_q != ST_IDLE);
    assign round_ok       = (state_q == ST_OK);
    assign round_fail     = (state_q == ST_FAIL);

endmodule

// File: tb/tb_player_checker.sv
// Directed bench for player_checker with a registered one-cycle sequence store model.
module tb_player_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] round_len;
    logic [2:0] btn;
    logic [1:0] current_number;
    logic [3:0] sequence_count;
    logic       busy;
    logic       round_ok;
    logic       round_fail;

    logic [1:0] mem [16];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         n;

    player_checker #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .round_len      (round_len),
        .btn            (btn),
        .current_number (current_number),
        .sequence_count (sequence_count),
        .busy           (busy),
        .round_ok       (round_ok),
        .round_fail     (round_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) current_number <= mem[sequence_count];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] oh(input logic [1:0] v);
        logic [2:0] one;
        one = 3'b001;
        return one << v;
    endfunction

    // Leaves the DUT in FETCH (one tick after start).
    task automatic start_round(input logic [3:0] len);
        round_len = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        btn   = 3'b000;
        round_len = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_seq", sequence_count, 0);
        chk("reset_ok", round_ok, 0);
        chk("reset_fail", round_fail, 0);

        // Full correct round of three presses: values 2,1,0.
        mem[0] = 2'd2; mem[1] = 2'd1; mem[2] = 2'd0;
        start_round(4'd2);
        chk("r3_fetch_busy", busy, 1);
        chk("r3_fetch_seq", sequence_count, 0);
        tick();
        btn = 3'b100; tick();
        btn = 3'b000; tick();
        chk("r3_seq1", sequence_count, 1);
        tick();
        btn = 3'b010; tick();
        btn = 3'b000; tick();
        chk("r3_seq2", sequence_count, 2);
        tick();
        btn = 3'b001; tick();
        chk("r3_release_busy", busy, 1);
        btn = 3'b000; tick();
        chk("r3_ok", round_ok, 1);
        chk("r3_no_fail", round_fail, 0);
        chk("r3_seq_end", sequence_count, 2);
        tick();
        chk("r3_ok_pulse_end", round_ok, 0);
        chk("r3_idle", busy, 0);
        chk("r3_seq_hold", sequence_count, 2);

        // Wrong value at index 0.
        mem[0] = 2'd2;
        start_round(4'd2);
        tick();
        btn = 3'b001; tick();
        chk("wrong_fail", round_fail, 1);
        chk("wrong_no_ok", round_ok, 0);
        chk("wrong_seq", sequence_count, 0);
        btn = 3'b000; tick();
        chk("wrong_idle", busy, 0);
        chk("wrong_pulse_end", round_fail, 0);

        // Timeout: no press at all.
        start_round(4'd0);
        tick();
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (round_fail) begin
                n = k;
                break;
            end
        end
        chk("timeout_latency", n, 8);
        tick();
        chk("timeout_idle", busy, 0);

        // Two buttons at once.
        mem[0] = 2'd1;
        start_round(4'd0);
        tick();
        btn = 3'b011; tick();
        chk("multi_fail", round_fail, 1);
        btn = 3'b000; tick();
        chk("multi_idle", busy, 0);

        // Button held through start is not a press until released and re-pressed.
        mem[0] = 2'd2;
        btn = 3'b100;
        tick();
        start_round(4'd0);
        tick();
        tick();
        tick();
        chk("held_busy", busy, 1);
        chk("held_no_fail", round_fail, 0);
        btn = 3'b000; tick();
        btn = 3'b100; tick();
        chk("held_release_busy", busy, 1);
        chk("held_release_no_fail", round_fail, 0);
        btn = 3'b000; tick();
        chk("held_ok", round_ok, 1);
        tick();

        // Reset in RELEASE at index 5.
        for (int i = 0; i < 16; i++) mem[i] = 2'(i % 3);
        start_round(4'd7);
        for (int i = 0; i < 6; i++) begin
            tick();
            btn = oh(mem[i]);
            tick();
            if (i < 5) begin
                btn = 3'b000;
                tick();
            end
        end
        chk("mid_seq5", sequence_count, 5);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_seq", sequence_count, 0);
        chk("mid_rst_ok", round_ok, 0);
        chk("mid_rst_fail", round_fail, 0);
        rst_n = 1'b1;
        btn   = 3'b000;
        tick();
        mem[0] = 2'd1;
        start_round(4'd0);
        chk("restart_seq", sequence_count, 0);
        chk("restart_busy", busy, 1);
        tick();
        btn = 3'b010; tick();
        btn = 3'b000; tick();
        chk("restart_ok", round_ok, 1);
        tick();

        // Longest round: indices 0..15 without wrap.
        for (int i = 0; i < 16; i++) mem[i] = 2'((i + 2) % 3);
        start_round(4'd15);
        for (int i = 0; i < 16; i++) begin
            chk("long_fetch_index", sequence_count, i);
            tick();
            btn = oh(mem[i]);
            tick();
            btn = 3'b000;
            tick();
        end
        chk("long_ok", round_ok, 1);
        chk("long_no_fail", round_fail, 0);
        chk("long_seq_end", sequence_count, 15);
        tick();
        chk("long_idle", busy, 0);
        chk("long_seq_hold", sequence_count, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
